// File: rtl/mem_pkg.sv
// mem_pkg: shared state type, byte-count helper and parameter legality check for mem_sp_ctrl
package mem_pkg;
  typedef enum logic {INIT, RUN} state_t;
  function automatic int bytes_of(int data_w);
    return data_w / 8;
  endfunction
  function automatic bit params_ok(int data_w, int addr_w, int depth);
    return (data_w % 8 == 0) && (depth >= 2) && (depth <= (1 << addr_w));
  endfunction
endpackage

// File: rtl/mem_sp_ctrl_if.sv
// mem_sp_ctrl_if: request/response valid-ready bus; master drives requests, slave drives responses
interface mem_sp_ctrl_if #(parameter int DATA_W = 8, parameter int ADDR_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master (output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/mem_sp_array.sv
// mem_sp_array: DEPTH x DATA_W storage, byte-enabled sync write, registered read, no reset (ports: clk, we, re, addr, be, wdata, rdata)
module mem_sp_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH),
  parameter int B = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [B-1:0]      be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < B; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_sp_ctrl.sv
// mem_sp_ctrl: single-port memory controller (ports: clk, rst, bus slave request/response channel, init_done)
module mem_sp_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_sp_ctrl_if.slave   bus,
  output logic           init_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int B = bytes_of(DATA_W);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  if (!params_ok(DATA_W, ADDR_W, DEPTH)) begin : g_bad
    $error("mem_sp_ctrl: DATA_W must be a multiple of 8 and 2 <= DEPTH <= 2**ADDR_W");
  end
  state_t state, nxt;
  logic [AW-1:0] cnt;
  logic [DATA_W-1:0] q;
  logic rv, err, in_range, acc, rd, clr;
  always_ff @(posedge clk) state <= rst ? INIT : nxt;
  always_comb nxt = (state == RUN || CLEAR_ON_RESET == 0 || cnt == LAST) ? RUN : INIT;
  always_comb begin
    init_done = !rst && state == RUN;
    bus.req_ready = init_done && (!rv || bus.rsp_ready);
    bus.rsp_valid = rv;
    bus.rsp_err = err;
    bus.rsp_rdata = (rv && !err) ? q : '0;
  end
  // extra MSB so DEPTH == 2**ADDR_W compares correctly
  assign in_range = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);
  assign acc = bus.req_valid && bus.req_ready;
  assign rd = acc && !bus.req_write;
  // the sweep never writes while rst is held, so reset alone leaves contents alone
  assign clr = !rst && state == INIT && CLEAR_ON_RESET != 0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (clr && cnt != LAST) cnt <= cnt + 1'b1;
  always_ff @(posedge clk)
    if (rst) begin
      rv <= 1'b0;
      err <= 1'b0;
    end else begin
      rv <= rd || (rv && !bus.rsp_ready);
      if (rd) err <= !in_range;
    end
  mem_sp_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk  (clk),
    .we   (clr || (acc && bus.req_write && in_range)),
    .re   (rd && in_range),
    .addr (clr ? cnt : bus.req_addr[AW-1:0]),
    .be   (clr ? {B{1'b1}} : bus.req_be),
    .wdata(clr ? '0 : bus.req_wdata),
    .rdata(q)
  );
endmodule
